hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//  Drives the write-enable (xW) and flush (xRST) inputs of the four pipeline registers
//  (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC enable. Stalls on dmem/imem wait and
//  load-use, flushes on a taken branch resolved in MEM, freezes on halt. It also keeps
//  stall/flush performance counters and a dmem wait timeout flag.
// PARAMETERS
//  CNT_W      32  width of stall_cnt / flush_cnt; counters saturate at all-ones
//  DWAIT_MAX  64  consecutive DWAIT cycles before mem_timeout is set
// PORTS
//  CLK         in   1   clock, rising edge
//  nRST        in   1   asynchronous active-low reset
//  ihit        in   1   imem returned the instruction this cycle
//  dhit        in   1   dmem completed the MEM-stage access this cycle
//  memcuDRE    in   1   MEM-stage load request
//  memcuDWE    in   1   MEM-stage store request
//  excuDRE     in   1   EX-stage instruction is a load
//  exwsel      in   5   EX-stage destination register
//  idrsel1     in   5   ID-stage rs
//  idrsel2     in   5   ID-stage rt
//  idUsesRt    in   1   ID-stage instruction reads rt as a source
//  brnch_taken in   1   MEM-stage branch/jump resolved taken
//  halt_wb     in   1   HALT instruction is in WB
//  pcW         out  1   PC load enable
//  ifW,idW,exW,memW     out 1 each  pipeline-register write enables
//  ifRST,idRST,exRST,memRST out 1 each  pipeline-register sync clear (bubble). Overrides xW
//  halt_out    out  1   CPU halted (registered, sticky)
//  mem_timeout out  1   dmem wait exceeded DWAIT_MAX (registered, sticky)
//  stall_cnt   out  CNT_W  cycles with pcW=0, excluding HALTED
//  flush_cnt   out  CNT_W  taken-branch flushes
// BEHAVIOUR
//  Reset (nRST=0): state=RUN, halt_out=0, mem_timeout=0, counters=0, wait_cnt=0.
//  While nRST=0: all xW=0, pcW=0, all xRST=1.
//  FSM states: RUN, DWAIT, HALTED. The state is registered. Outputs are combinational from state and inputs.
//  Let dreq=memcuDRE|memcuDWE.
//  Let lu = excuDRE & exwsel!=0 & (exwsel==idrsel1 | (idUsesRt & exwsel==idrsel2)).
//  Output priority, highest first (the defaults are all xW=1, pcW=1, all xRST=0):
//   1 HALTED, or halt_wb in RUN: all W=0, pcW=0, all RST=0. Next state = HALTED. halt_out=1 from next cycle.
//     HALTED exits only on reset.
//   2 dreq & !dhit: pcW=ifW=idW=exW=0, memW=0, memRST=1 (bubble into WB). Next state = DWAIT.
//   3 brnch_taken: pcW=1, ifRST=idRST=exRST=1. memW=1. flush_cnt++.
//   4 lu: pcW=0, ifW=0, idRST=1 (bubble into EX). exW=memW=1. One cycle per hazard.
//   5 !ihit: pcW=0, ifRST=1 (bubble into ID). idW=exW=memW=1.
//  DWAIT: the same outputs as rule 2 until dhit=1. In the dhit cycle, evaluate rules 3-5 as in RUN,
//   and go back to RUN.
//  wait_cnt: increments each DWAIT cycle and clears on leaving DWAIT.
//   At wait_cnt==DWAIT_MAX-1, mem_timeout<=1. The freeze continues.
//  stall_cnt: increments in every non-HALTED cycle with pcW=0.
//  Both counters saturate and never wrap.
//  Simultaneous events:
//   - dmem wait + branch: freeze first. The branch flushes in the dhit cycle (MEM is frozen, so brnch_taken holds).
//   - branch + load-use or !ihit: the branch wins, pcW=1.
//   - load-use + !ihit: rule 4.
//  Async reset mid-DWAIT or mid-HALTED returns to RUN with all outputs at their reset values.
// TESTING
//  1 Reset mid-stream: pulse nRST low. All RST=1, W=0, pcW=0. After release with ihit=1: all W=1, RST=0.
//  2 Load-use: excuDRE=1, exwsel=5, idrsel1=5, ihit=1 -> exactly one cycle of pcW=0, ifW=0, idRST=1.
//    exwsel=0 gives no stall.
//  3 dmem wait: memcuDRE=1, dhit=0 for 3 cycles, then 1 -> 3 frozen cycles with memRST=1, then advance.
//    stall_cnt=3.
//  4 Branch during wait: brnch_taken=1 with dreq, dhit=0 for 2 cycles -> freeze, then the flush happens
//    in the dhit cycle. flush_cnt=1.
//  5 Timeout: DWAIT_MAX=4, dhit held 0 -> mem_timeout=1 after the 4th DWAIT cycle, and it stays set
//    after dhit.
//  6 Halt: halt_wb=1 -> halt_out=1 next cycle, all W=0 forever. stall_cnt frozen until nRST.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: stalls, bubbles and flushes for a 5-stage pipeline,
// with a sticky halt, dmem wait timeout and saturating stall/flush counters.
module hazard_control_unit #(
   parameter int CNT_W     = 32,
   parameter int DWAIT_MAX = 64
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             memcuDRE,
   input  logic             memcuDWE,
   input  logic             excuDRE,
   input  logic [4:0]       exwsel,
   input  logic [4:0]       idrsel1,
   input  logic [4:0]       idrsel2,
   input  logic             idUsesRt,
   input  logic             brnch_taken,
   input  logic             halt_wb,
   output logic             pcW,
   output logic             ifW,
   output logic             idW,
   output logic             exW,
   output logic             memW,
   output logic             ifRST,
   output logic             idRST,
   output logic             exRST,
   output logic             memRST,
   output logic             halt_out,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WW = $clog2(DWAIT_MAX) + 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(DWAIT_MAX - 1);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   state_t           state_q, state_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic             halt_out_q, halt_out_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic dreq, lu;
   logic frz_halt, frz_mem, normal, do_flush, do_lu, do_imiss;

   assign dreq = memcuDRE | memcuDWE;
   assign lu   = excuDRE & (exwsel != 5'd0) &
                 ((exwsel == idrsel1) | (idUsesRt & (exwsel == idrsel2)));

   // Rule selection in priority order; in DWAIT a dhit cycle behaves like RUN minus halt.
   assign frz_halt = (state_q == HALTED) | ((state_q == RUN) & halt_wb);
   assign frz_mem  = ~frz_halt & (((state_q == RUN) & dreq & ~dhit) |
                                  ((state_q == DWAIT) & ~dhit));
   assign normal   = ~frz_halt & ~frz_mem;
   assign do_flush = normal & brnch_taken;
   assign do_lu    = normal & ~brnch_taken & lu;
   assign do_imiss = normal & ~brnch_taken & ~lu & ~ihit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         halt_out_q    <= 1'b0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         halt_out_q    <= halt_out_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (halt_wb)
               state_d = HALTED;
            else if (dreq & ~dhit)
               state_d = DWAIT;
         end
         DWAIT:   if (dhit) state_d = RUN;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pcW    = 1'b1;
      ifW    = 1'b1;
      idW    = 1'b1;
      exW    = 1'b1;
      memW   = 1'b1;
      ifRST  = 1'b0;
      idRST  = 1'b0;
      exRST  = 1'b0;
      memRST = 1'b0;
      if (!nRST) begin
         {pcW, ifW, idW, exW, memW}     = '0;
         {ifRST, idRST, exRST, memRST}  = '1;
      end else if (frz_halt) begin
         {pcW, ifW, idW, exW, memW}     = '0;
      end else if (frz_mem) begin
         {pcW, ifW, idW, exW, memW}     = '0;
         memRST = 1'b1;
      end else if (do_flush) begin
         {ifRST, idRST, exRST}          = '1;
      end else if (do_lu) begin
         pcW   = 1'b0;
         ifW   = 1'b0;
         idRST = 1'b1;
      end else if (do_imiss) begin
         pcW   = 1'b0;
         ifRST = 1'b1;
      end
   end

   // Bookkeeping registers; all counters saturate instead of wrapping.
   always_comb begin
      halt_out_d    = halt_out_q | (state_d == HALTED);
      mem_timeout_d = mem_timeout_q | ((state_q == DWAIT) & (wait_cnt_q == WAIT_LAST));
      wait_cnt_d    = '0;
      if ((state_q == DWAIT) && (state_d == DWAIT))
         wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WW'(1);
      stall_cnt_d = stall_cnt_q;
      if ((state_q != HALTED) && !pcW && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (do_flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   assign halt_out    = halt_out_q;
   assign mem_timeout = mem_timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
